// File: rtl/netlist_vector_sequencer.sv
// rtl/netlist_vector_sequencer.sv - stimulus sequencer and response checker for a combinational netlist
//
// Purpose:
//   Accepts one stimulus vector at a time and drives it onto the netlist inputs.
//   After SETTLE wait cycles it captures the netlist outputs and compares them
//   against the expected word. It also keeps saturating vector and error counters
//   and a MISR signature over every captured output.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   vec_valid/vec_ready       stimulus handshake (vec_in, exp_in, cmp_en)
//   dut_in / dut_out          registered netlist drive / netlist response
//   res_valid/res_ready       result handshake (res_data, res_match)
//   vec_cnt, err_cnt, sig     captured-vector count, mismatch count, MISR
//   clr                       synchronous clear of vec_cnt, err_cnt and sig
module netlist_vector_sequencer #(
  parameter int               IN_W   = 14,
  parameter int               OUT_W  = 8,
  parameter int               SETTLE = 2,
  parameter int               CNT_W  = 16,
  parameter logic [OUT_W-1:0] TAPS   = 8'h1D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_in,
  input  logic [OUT_W-1:0] exp_in,
  input  logic             cmp_en,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             res_match,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [OUT_W-1:0] sig,
  input  logic             clr
);

  localparam logic [7:0] SETTLE_V = 8'(SETTLE);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_q;
  logic [7:0]       timer_q;
  logic [IN_W-1:0]  dut_in_q;
  logic [OUT_W-1:0] exp_q;
  logic             cmp_q;
  logic [OUT_W-1:0] res_data_q;
  logic             res_match_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [OUT_W-1:0] sig_q;

  logic [OUT_W-1:0] sig_d;
  logic [CNT_W-1:0] vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic             mismatch;

  // MISR: shift left, fold the outgoing MSB back through the taps, mix in the sample.
  assign sig_d     = ({sig_q[OUT_W-2:0], 1'b0} ^ (sig_q[OUT_W-1] ? TAPS : '0)) ^ dut_out;
  assign mismatch  = (dut_out != exp_q);
  // Counters stick at all-ones rather than wrapping.
  assign vec_cnt_d = (vec_cnt_q == '1) ? vec_cnt_q : vec_cnt_q + CNT_W'(1);
  assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      dut_in_q    <= '0;
      exp_q       <= '0;
      cmp_q       <= 1'b0;
      res_data_q  <= '0;
      res_match_q <= 1'b0;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      sig_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vec_valid) begin
            dut_in_q <= vec_in;
            exp_q    <= exp_in;
            cmp_q    <= cmp_en;
            timer_q  <= SETTLE_V;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (timer_q != 8'd0) begin
            timer_q <= timer_q - 8'd1;
          end else begin
            res_data_q  <= dut_out;
            res_match_q <= !cmp_q || !mismatch;
            vec_cnt_q   <= vec_cnt_d;
            if (cmp_q && mismatch) err_cnt_q <= err_cnt_d;
            sig_q       <= sig_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Placed after the FSM so a clear on the capture edge overrides the accumulation.
      if (clr) begin
        vec_cnt_q <= '0;
        err_cnt_q <= '0;
        sig_q     <= '0;
      end
    end
  end

  assign vec_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign dut_in    = dut_in_q;
  assign res_data  = res_data_q;
  assign res_match = res_match_q;
  assign vec_cnt   = vec_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign sig       = sig_q;

endmodule

// File: tb/tb_netlist_vector_sequencer.sv
// tb/tb_netlist_vector_sequencer.sv - directed self-checking bench for netlist_vector_sequencer
module tb_netlist_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instance A: SETTLE=2, CNT_W=16
  logic        rst_a, a_vec_valid, a_vec_ready, a_cmp_en, a_res_valid, a_res_ready;
  logic        a_res_match, a_clr;
  logic [13:0] a_vec_in, a_dut_in;
  logic [7:0]  a_exp_in, a_dut_out, a_res_data, a_sig;
  logic [15:0] a_vec_cnt, a_err_cnt;

  // Netlist stand-in: out = in[7:0] ^ {2'b00, in[13:8]}
  assign a_dut_out = a_dut_in[7:0] ^ {2'b00, a_dut_in[13:8]};

  netlist_vector_sequencer #(.SETTLE(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst_a), .vec_valid(a_vec_valid), .vec_ready(a_vec_ready),
    .vec_in(a_vec_in), .exp_in(a_exp_in), .cmp_en(a_cmp_en), .dut_in(a_dut_in),
    .dut_out(a_dut_out), .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_data(a_res_data), .res_match(a_res_match), .vec_cnt(a_vec_cnt),
    .err_cnt(a_err_cnt), .sig(a_sig), .clr(a_clr)
  );

  // Instance B: SETTLE=5, CNT_W=4
  logic        rst_b, b_vec_valid, b_vec_ready, b_cmp_en, b_res_valid, b_res_ready;
  logic        b_res_match, b_clr;
  logic [13:0] b_vec_in, b_dut_in;
  logic [7:0]  b_exp_in, b_dut_out, b_res_data, b_sig;
  logic [3:0]  b_vec_cnt, b_err_cnt;

  assign b_dut_out = b_dut_in[7:0] ^ {2'b00, b_dut_in[13:8]};

  netlist_vector_sequencer #(.SETTLE(5), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst_b), .vec_valid(b_vec_valid), .vec_ready(b_vec_ready),
    .vec_in(b_vec_in), .exp_in(b_exp_in), .cmp_en(b_cmp_en), .dut_in(b_dut_in),
    .dut_out(b_dut_out), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_data(b_res_data), .res_match(b_res_match), .vec_cnt(b_vec_cnt),
    .err_cnt(b_err_cnt), .sig(b_sig), .clr(b_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one vector to A and returns with res_valid high (before the DONE edge).
  // clr_cap raises clr for exactly the capture edge E3.
  task automatic send_a(input logic [13:0] v, input logic [7:0] e, input logic c, input bit clr_cap);
    int n;
    a_vec_in = v; a_exp_in = e; a_cmp_en = c; a_vec_valid = 1'b1;
    n = 0;
    while (!a_vec_ready && n < 50) begin step(); n++; end
    if (n >= 50) check_eq("a_accept_timeout", 32'(n), 32'd0);
    step();
    a_vec_valid = 1'b0;
    check_eq("a_dut_in_after_E0", 32'(a_dut_in), 32'(v));
    n = 0;
    while (!a_res_valid && n < 50) begin
      if (clr_cap && n == 2) a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      n++;
    end
    check_eq("a_latency", 32'(n), 32'd3);
  endtask

  task automatic send_b(input logic [13:0] v, input logic [7:0] e);
    int n;
    b_vec_in = v; b_exp_in = e; b_cmp_en = 1'b1; b_vec_valid = 1'b1;
    n = 0;
    while (!b_vec_ready && n < 50) begin step(); n++; end
    if (n >= 50) check_eq("b_accept_timeout", 32'(n), 32'd0);
    step();
    b_vec_valid = 1'b0;
    n = 0;
    while (!b_res_valid && n < 50) begin step(); n++; end
    if (n >= 50) check_eq("b_result_timeout", 32'(n), 32'd0);
    step();
  endtask

  initial begin
    int n;
    bit seen;
    rst_a = 1'b1; a_vec_valid = 1'b0; a_vec_in = '0; a_exp_in = '0; a_cmp_en = 1'b0;
    a_res_ready = 1'b1; a_clr = 1'b0;
    rst_b = 1'b1; b_vec_valid = 1'b0; b_vec_in = '0; b_exp_in = '0; b_cmp_en = 1'b0;
    b_res_ready = 1'b1; b_clr = 1'b0;
    repeat (3) step();

    // Reset state
    check_eq("rst_vec_ready", 32'(a_vec_ready), 32'd1);
    check_eq("rst_dut_in", 32'(a_dut_in), 32'd0);
    check_eq("rst_res_valid", 32'(a_res_valid), 32'd0);
    check_eq("rst_res_data", 32'(a_res_data), 32'd0);
    check_eq("rst_res_match", 32'(a_res_match), 32'd0);
    check_eq("rst_vec_cnt", 32'(a_vec_cnt), 32'd0);
    check_eq("rst_err_cnt", 32'(a_err_cnt), 32'd0);
    check_eq("rst_sig", 32'(a_sig), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // Basic match: 0x1234 -> 0x34 ^ 0x12 = 0x26
    send_a(14'h1234, 8'h26, 1'b1, 1'b0);
    check_eq("basic_res_data", 32'(a_res_data), 32'h26);
    check_eq("basic_res_match", 32'(a_res_match), 32'd1);
    check_eq("basic_vec_cnt", 32'(a_vec_cnt), 32'd1);
    check_eq("basic_err_cnt", 32'(a_err_cnt), 32'd0);
    check_eq("basic_sig", 32'(a_sig), 32'h26);
    step();
    check_eq("basic_back_idle", 32'(a_vec_ready), 32'd1);
    check_eq("basic_res_valid_low", 32'(a_res_valid), 32'd0);
    check_eq("basic_dut_in_hold", 32'(a_dut_in), 32'h1234);

    // clr in IDLE clears stats only
    a_clr = 1'b1; step(); a_clr = 1'b0;
    check_eq("clr_vec_cnt", 32'(a_vec_cnt), 32'd0);
    check_eq("clr_sig", 32'(a_sig), 32'd0);
    check_eq("clr_dut_in_kept", 32'(a_dut_in), 32'h1234);

    // Mismatch and MISR: outputs 0xA5 then 0x3C, expected 0x00
    send_a(14'h00A5, 8'h00, 1'b1, 1'b0);
    check_eq("mm1_res_data", 32'(a_res_data), 32'hA5);
    check_eq("mm1_res_match", 32'(a_res_match), 32'd0);
    check_eq("mm1_err_cnt", 32'(a_err_cnt), 32'd1);
    check_eq("mm1_sig", 32'(a_sig), 32'hA5);
    step();
    send_a(14'h003C, 8'h00, 1'b1, 1'b0);
    check_eq("mm2_err_cnt", 32'(a_err_cnt), 32'd2);
    check_eq("mm2_vec_cnt", 32'(a_vec_cnt), 32'd2);
    check_eq("mm2_sig", 32'(a_sig), 32'h6B);
    step();

    // Compare disabled: output 0x01 vs exp 0x00 still reports a match
    send_a(14'h0100, 8'h00, 1'b0, 1'b0);
    check_eq("nocmp_res_match", 32'(a_res_match), 32'd1);
    check_eq("nocmp_err_cnt", 32'(a_err_cnt), 32'd2);
    check_eq("nocmp_vec_cnt", 32'(a_vec_cnt), 32'd3);
    check_eq("nocmp_sig", 32'(a_sig), 32'hD7);
    step();

    // Backpressure: hold res_ready low 10 cycles while a new vector is offered
    a_res_ready = 1'b0;
    send_a(14'h0055, 8'h55, 1'b1, 1'b0);
    a_vec_in = 14'h0AAA; a_exp_in = 8'h00; a_cmp_en = 1'b1; a_vec_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_res_valid", 32'(a_res_valid), 32'd1);
      check_eq("bp_res_data", 32'(a_res_data), 32'h55);
      check_eq("bp_res_match", 32'(a_res_match), 32'd1);
      check_eq("bp_vec_ready", 32'(a_vec_ready), 32'd0);
      check_eq("bp_dut_in", 32'(a_dut_in), 32'h0055);
    end
    a_res_ready = 1'b1;
    step();
    check_eq("bp_release_ready", 32'(a_vec_ready), 32'd1);
    check_eq("bp_release_valid", 32'(a_res_valid), 32'd0);
    check_eq("bp_not_yet_accepted", 32'(a_dut_in), 32'h0055);
    step();
    a_vec_valid = 1'b0;
    check_eq("bp_accepted", 32'(a_dut_in), 32'h0AAA);
    check_eq("bp_busy", 32'(a_vec_ready), 32'd0);
    n = 0;
    while (!a_res_valid && n < 50) begin step(); n++; end
    check_eq("bp_drain_latency", 32'(n), 32'd3);
    step();

    // clr exactly on the capture edge of a mismatching vector
    send_a(14'h0011, 8'hFF, 1'b1, 1'b1);
    check_eq("clrcap_vec_cnt", 32'(a_vec_cnt), 32'd0);
    check_eq("clrcap_err_cnt", 32'(a_err_cnt), 32'd0);
    check_eq("clrcap_sig", 32'(a_sig), 32'd0);
    check_eq("clrcap_res_valid", 32'(a_res_valid), 32'd1);
    check_eq("clrcap_res_match", 32'(a_res_match), 32'd0);
    check_eq("clrcap_res_data", 32'(a_res_data), 32'h11);
    step();
    send_a(14'h0002, 8'h02, 1'b1, 1'b0);
    check_eq("after_clr_vec_cnt", 32'(a_vec_cnt), 32'd1);
    check_eq("after_clr_sig", 32'(a_sig), 32'h02);
    step();

    // Saturation on B: 20 mismatching vectors with a 4-bit counter
    for (int i = 0; i < 20; i++) send_b(14'h0001, 8'h00);
    check_eq("sat_vec_cnt", 32'(b_vec_cnt), 32'hF);
    check_eq("sat_err_cnt", 32'(b_err_cnt), 32'hF);

    // Reset two cycles after acceptance while in WAIT (SETTLE=5)
    b_vec_in = 14'h0003; b_exp_in = 8'h00; b_cmp_en = 1'b1; b_vec_valid = 1'b1;
    n = 0;
    while (!b_vec_ready && n < 50) begin step(); n++; end
    step();
    b_vec_valid = 1'b0;
    check_eq("wrst_dut_in_E0", 32'(b_dut_in), 32'h0003);
    step();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    check_eq("wrst_vec_ready", 32'(b_vec_ready), 32'd1);
    check_eq("wrst_dut_in", 32'(b_dut_in), 32'd0);
    check_eq("wrst_res_valid", 32'(b_res_valid), 32'd0);
    check_eq("wrst_vec_cnt", 32'(b_vec_cnt), 32'd0);
    check_eq("wrst_err_cnt", 32'(b_err_cnt), 32'd0);
    check_eq("wrst_sig", 32'(b_sig), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b_res_valid) seen = 1'b1;
    end
    check_eq("wrst_no_result", 32'(seen), 32'd0);
    check_eq("wrst_cnt_still_0", 32'(b_vec_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/netlist_vector_sequencer.md
# netlist_vector_sequencer

Sequences stimulus into the mapped combinational benchmark netlist and collects its responses for equivalence and regression checks. It accepts one input vector at a time over a valid/ready handshake and drives it onto the netlist's 14 primary inputs. After a programmable settle window it samples the 8 primary outputs and compares them against an expected word. It also maintains pass/fail counters and a MISR signature, so an optimized netlist can be checked against its golden response stream.

## Interface

Parameters:
- IN_W, 14: width of the netlist primary-input bus.
- OUT_W, 8: width of the netlist primary-output bus.
- SETTLE, 2: number of wait cycles between driving dut_in and sampling dut_out; range 0..255.
- CNT_W, 16: width of the vector and error counters.
- TAPS, 8'h1D: MISR feedback polynomial, OUT_W bits.

Ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- vec_valid  in  1  stimulus vector offered.
- vec_ready  out  1  sequencer can accept a vector.
- vec_in  in  IN_W  stimulus vector.
- exp_in  in  OUT_W  expected netlist output for vec_in.
- cmp_en  in  1  compare this vector; sampled with vec_in.
- dut_in  out  IN_W  registered drive to the netlist primary inputs.
- dut_out  in  OUT_W  netlist primary outputs.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_data  out  OUT_W  captured dut_out.
- res_match  out  1  1 when compare was disabled or the captured value equals the expected word.
- vec_cnt  out  CNT_W  number of vectors captured; saturating.
- err_cnt  out  CNT_W  number of compared vectors that mismatched; saturating.
- sig  out  OUT_W  MISR signature of all captured outputs.
- clr  in  1  synchronous clear of vec_cnt, err_cnt and sig.

## Operation

- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- vec_ready = (state == IDLE). It is a pure state decode with no combinational path from vec_valid.
- **IDLE**: on vec_valid && vec_ready:
  - dut_in <= vec_in; exp_in and cmp_en are latched internally.
  - timer <= SETTLE; state goes to WAIT.
- **WAIT**: if timer != 0, timer decrements. If timer == 0, the capture edge occurs:
  - res_data <= dut_out.
  - res_match <= !cmp || (dut_out == exp).
  - vec_cnt increments.
  - err_cnt increments only if cmp && mismatch.
  - sig updates.
  - state goes to DONE.
- **DONE**: res_valid = 1. While res_ready = 0, res_valid, res_data and res_match hold stable. On res_ready = 1, state goes to IDLE.
- dut_in holds its value from acceptance until the next acceptance. It is never changed in WAIT or DONE.
- MISR update rule: sig <= ({sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? TAPS : 0)) ^ dut_out.
- Counters saturate at all-ones and never wrap.
- clr is honoured in any state. When clr coincides with a capture edge, clr wins: vec_cnt, err_cnt and sig become 0, and that capture is not counted. res_data and res_match are still loaded, and the FSM still advances.
- clr does not affect the FSM, dut_in or the pending result.

## Timing

- Reset values:
  - state = IDLE, so vec_ready = 1.
  - dut_in = 0.
  - res_valid = 0, res_data = 0, res_match = 0.
  - vec_cnt = 0, err_cnt = 0, sig = 0, timer = 0.
- Let the acceptance edge be E0.
  - dut_in is valid after E0.
  - The capture edge is E(SETTLE+1).
  - res_valid is high from E(SETTLE+1) until the edge where res_ready is sampled high.
- With SETTLE = 0, capture is at E1, so dut_out is sampled one full cycle after dut_in changes.
- Minimum vector period is SETTLE + 3 cycles when res_ready is held high: accept, SETTLE+1 cycles in WAIT, 1 cycle in DONE, then back to IDLE.
- rst mid-operation, in WAIT or DONE, aborts the vector: no capture, no counter update, and all outputs return to their reset values on the next edge.
- vec_valid presented in WAIT or DONE is ignored. The producer must hold it until vec_ready is high.

## Test plan

- **Basic match**: SETTLE=2, vec_in=14'h1234, exp_in set to the golden netlist output, cmp_en=1, res_ready=1 -> dut_in=14'h1234 after E0; res_valid rises after E3; res_match=1; vec_cnt=1, err_cnt=0.
- **Mismatch and MISR**: two compared vectors whose captured outputs are 8'hA5 then 8'h3C, exp_in=8'h00 for both -> err_cnt=2; sig=8'hA5 after the first capture, 8'h6B after the second.
- **Backpressure**: res_ready=0 for 10 cycles in DONE -> res_valid, res_data and res_match stable; vec_ready=0 throughout; a new vec_valid is not accepted until one cycle after res_ready=1.
- **Saturation**: CNT_W=4, 20 mismatching compared vectors -> vec_cnt=err_cnt=4'hF, with no wrap to 0.
- **clr on capture edge**: assert clr exactly on the capture edge of a mismatching vector -> vec_cnt=0, err_cnt=0, sig=0; res_valid=1 with res_match=0.
- **Reset mid-WAIT**: SETTLE=5, assert rst two cycles after acceptance -> next cycle: state IDLE, vec_ready=1, dut_in=0, res_valid=0, counters 0; no result is ever produced for the aborted vector.
